lcd_pixel_stream: RTL and testbench



---
 rtl/lcd_pixel_stream.sv | 197 +++++++++++++++++++
 tb/tb_lcd_pixel_stream.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pixel_stream.sv
// -----------------------------------------------------------------------------
// lcd_pixel_stream
//
// Buffers an RGB565 pixel stream from a valid/ready producer and replays it on
// the active-display cycles of an LCD timing generator. Producer frames are
// re-aligned to the generator's VSYNC, and a constant fill colour is driven
// whenever no valid pixel is available. DE/HSYNC/VSYNC are delayed by one
// cycle so they line up with the registered pixel outputs.
//
// Ports:
//   PixelClk          pixel clock
//   nRST              asynchronous active-low reset
//   s_valid/s_ready   producer handshake (s_ready = FIFO not full)
//   s_data[15:0]      RGB565 pixel, [15:11]=R, [10:5]=G, [4:0]=B
//   s_sof             first pixel of a producer frame
//   de_in/hsync_in/vsync_in  timing generator inputs
//   LCD_DE/LCD_HSYNC/LCD_VSYNC  timing inputs delayed by one cycle
//   LCD_R/LCD_G/LCD_B registered pixel outputs (0 outside DE)
//   underflow         one-cycle pulse per underflow or early-SOF event
//
// Optional build macro LCD_PIXEL_STREAM_STATS_EN adds:
//   underflow_count[15:0]          saturating underflow count, cleared on fs
//   fifo_level[$clog2(DEPTH):0]    live FIFO occupancy
//
// State table:
//   SYNC | waiting for frame start; non-SOF heads are discarded, SOF head held
//   RUN  | streaming FIFO pixels on each DE cycle
// -----------------------------------------------------------------------------
module lcd_pixel_stream #(
  parameter int unsigned DEPTH    = 64,
  parameter logic [15:0] FILL_RGB = 16'h0000,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic                    PixelClk,
  input  logic                    nRST,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [15:0]             s_data,
  input  logic                    s_sof,
  input  logic                    de_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  output logic                    LCD_DE,
  output logic                    LCD_HSYNC,
  output logic                    LCD_VSYNC,
  output logic [4:0]              LCD_R,
  output logic [5:0]              LCD_G,
  output logic [4:0]              LCD_B,
`ifdef LCD_PIXEL_STREAM_STATS_EN
  output logic [15:0]             underflow_count,
  output logic [$clog2(DEPTH):0]  fifo_level,
`endif
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  // FIFO storage: each entry is {sof, data}
  logic [16:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        wr_en;
  logic        pop;
  logic        head_sof;
  logic [15:0] head_data;

  state_t      state;
  logic        first_px;
  logic        vs_q;
  logic        fs;

  state_t      st_eff;
  logic        first_eff;
  state_t      st_next;
  logic        first_next;
  logic        uf_evt;
  logic [15:0] px_next;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign s_ready = !full;
  assign wr_en   = s_valid && !full;

  // Head is read straight from the registered array, so a word written this
  // cycle only becomes visible on the next one.
  assign head_sof  = mem[rd_ptr[AW-1:0]][16];
  assign head_data = mem[rd_ptr[AW-1:0]][15:0];

  // Frame start: first cycle of the VSYNC pulse.
  assign fs = (vsync_in == VS_POL) && (vs_q != VS_POL);

  always_ff @(posedge PixelClk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {s_sof, s_data};
    end
  end

  // Frame start is resolved first; the DE rules then run on the resulting
  // state so a fs coinciding with DE behaves like fs followed by DE.
  always_comb begin
    st_eff    = state;
    first_eff = first_px;
    if (fs) begin
      if (!empty && head_sof) begin
        st_eff    = RUN;
        first_eff = 1'b1;
      end else begin
        st_eff    = SYNC;
        first_eff = 1'b0;
      end
    end

    pop        = 1'b0;
    uf_evt     = 1'b0;
    px_next    = FILL_RGB;
    st_next    = st_eff;
    first_next = first_eff;

    if (st_eff == SYNC) begin
      // Drop leftovers of an abandoned frame until a SOF word reaches the head.
      pop = !empty && !head_sof;
    end else if (de_in) begin
      if (empty) begin
        uf_evt     = 1'b1;
        st_next    = SYNC;
        first_next = 1'b0;
      end else if (head_sof && !first_eff) begin
        // Next frame arrived before this one finished; keep the SOF word.
        uf_evt     = 1'b1;
        st_next    = SYNC;
        first_next = 1'b0;
      end else begin
        pop        = 1'b1;
        px_next    = head_data;
        first_next = 1'b0;
      end
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state     <= SYNC;
      first_px  <= 1'b0;
      vs_q      <= ~VS_POL;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      LCD_DE    <= 1'b0;
      LCD_HSYNC <= 1'b1;
      LCD_VSYNC <= ~VS_POL;
      LCD_R     <= '0;
      LCD_G     <= '0;
      LCD_B     <= '0;
      underflow <= 1'b0;
    end else begin
      state     <= st_next;
      first_px  <= first_next;
      vs_q      <= vsync_in;
      if (wr_en) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      LCD_DE    <= de_in;
      LCD_HSYNC <= hsync_in;
      LCD_VSYNC <= vsync_in;
      LCD_R     <= de_in ? px_next[15:11] : 5'd0;
      LCD_G     <= de_in ? px_next[10:5]  : 6'd0;
      LCD_B     <= de_in ? px_next[4:0]   : 5'd0;
      underflow <= uf_evt;
    end
  end

`ifdef LCD_PIXEL_STREAM_STATS_EN
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      underflow_count <= '0;
    end else if (fs) begin
      underflow_count <= '0;
    end else if (uf_evt && (underflow_count != 16'hFFFF)) begin
      underflow_count <= underflow_count + 16'd1;
    end
  end

  assign fifo_level = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_lcd_pixel_stream.sv
module tb_lcd_pixel_stream;

  logic        PixelClk = 1'b0;
  logic        nRST;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        s_sof;
  logic        de_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        LCD_DE;
  logic        LCD_HSYNC;
  logic        LCD_VSYNC;
  logic [4:0]  LCD_R;
  logic [5:0]  LCD_G;
  logic [4:0]  LCD_B;
  logic        underflow;
`ifdef LCD_PIXEL_STREAM_STATS_EN
  logic [15:0] underflow_count;
  logic [6:0]  fifo_level;
`endif

  int          tests = 0;
  int          fails = 0;

  // producer model state
  int          prod_idx  = 0;
  int          prod_n    = 0;
  logic [15:0] prod_base = 16'h0000;
  int          sof_a     = -1;
  int          sof_b     = -1;

  logic [15:0] px;
  assign px = {LCD_R, LCD_G, LCD_B};

  always #5 PixelClk = ~PixelClk;

  lcd_pixel_stream #(.DEPTH(64), .FILL_RGB(16'h0000), .VS_POL(1'b1)) dut (
    .PixelClk  (PixelClk),
    .nRST      (nRST),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .de_in     (de_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .LCD_DE    (LCD_DE),
    .LCD_HSYNC (LCD_HSYNC),
    .LCD_VSYNC (LCD_VSYNC),
    .LCD_R     (LCD_R),
    .LCD_G     (LCD_G),
    .LCD_B     (LCD_B),
`ifdef LCD_PIXEL_STREAM_STATS_EN
    .underflow_count (underflow_count),
    .fifo_level      (fifo_level),
`endif
    .underflow (underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive producer + timing inputs, clock, then check the
  // one-cycle-delayed sync outputs.
  task automatic step(input logic de, input logic vs, input logic hs);
    logic acc;
    if (prod_idx < prod_n && s_ready) begin
      s_valid = 1'b1;
      s_data  = prod_base + 16'(prod_idx);
      s_sof   = (prod_idx == sof_a) || (prod_idx == sof_b);
    end else begin
      s_valid = 1'b0;
      s_data  = 16'h0000;
      s_sof   = 1'b0;
    end
    acc      = s_valid && s_ready;
    de_in    = de;
    vsync_in = vs;
    hsync_in = hs;
    @(posedge PixelClk);
    #1;
    if (acc) prod_idx++;
    check("lcd_de", {31'd0, LCD_DE}, {31'd0, de});
    check("lcd_vsync", {31'd0, LCD_VSYNC}, {31'd0, vs});
    check("lcd_hsync", {31'd0, LCD_HSYNC}, {31'd0, hs});
  endtask

  task automatic expect_px(input string tag, input logic [15:0] exp_px, input logic exp_uf);
    check(tag, {16'd0, px}, {16'd0, exp_px});
    check({tag, "_uf"}, {31'd0, underflow}, {31'd0, exp_uf});
  endtask

  task automatic start_producer(input logic [15:0] base, input int n, input int sa, input int sb);
    prod_base = base;
    prod_n    = n;
    prod_idx  = 0;
    sof_a     = sa;
    sof_b     = sb;
  endtask

  initial begin
    nRST     = 1'b0;
    s_valid  = 1'b0;
    s_data   = 16'h0000;
    s_sof    = 1'b0;
    de_in    = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b0;

    // reset state
    #12;
    check("rst_hsync", {31'd0, LCD_HSYNC}, 32'd1);
    check("rst_vsync", {31'd0, LCD_VSYNC}, 32'd0);
    check("rst_de", {31'd0, LCD_DE}, 32'd0);
    check("rst_rgb", {16'd0, px}, 32'd0);
    check("rst_ready", {31'd0, s_ready}, 32'd1);
    check("rst_uf", {31'd0, underflow}, 32'd0);
    @(negedge PixelClk);
    nRST = 1'b1;

    // sync delay sanity
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // 800-pixel frame streamed through the FIFO
    start_producer(16'h0000, 800, 0, -1);
    for (int i = 0; i < 70; i++) step(1'b0, 1'b0, 1'b1);
    check("preload_cnt", prod_idx, 64);
    check("preload_full", {31'd0, s_ready}, 32'd0);
    step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 800; k++) begin
      step(1'b1, 1'b0, 1'b1);
      expect_px("frame800", 16'(k), 1'b0);
    end
    step(1'b0, 1'b0, 1'b1);
    expect_px("blank_after", 16'h0000, 1'b0);

    // short frame -> underflow at DE cycle 11, then SYNC (no more pulses)
    start_producer(16'h0100, 10, 0, -1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 1'b1);
      if (k < 10) expect_px("short_px", 16'h0100 + 16'(k), 1'b0);
      else        expect_px("short_fill", 16'h0000, k == 10);
    end

    // 5 non-SOF words discarded, SOF word held until fs
    start_producer(16'h0A00, 6, 5, -1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    expect_px("sof_held", 16'h0A05, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    expect_px("sof_empty", 16'h0000, 1'b1);

    // back-pressure: exactly 64 writes, one pop frees a slot
    start_producer(16'h0500, 200, 0, -1);
    for (int i = 0; i < 70; i++) step(1'b0, 1'b0, 1'b1);
    check("full_cnt", prod_idx, 64);
    check("full_ready", {31'd0, s_ready}, 32'd0);
    step(1'b0, 1'b1, 1'b1);
    check("full_ready_fs", {31'd0, s_ready}, 32'd0);
    step(1'b1, 1'b0, 1'b1);
    expect_px("full_pop", 16'h0500, 1'b0);
    check("ready_after_pop", {31'd0, s_ready}, 32'd1);
    prod_n = prod_idx;

    // mid-frame reset clears everything
    nRST = 1'b0;
    #2;
    check("rst2_vsync", {31'd0, LCD_VSYNC}, 32'd0);
    check("rst2_hsync", {31'd0, LCD_HSYNC}, 32'd1);
    check("rst2_de", {31'd0, LCD_DE}, 32'd0);
    check("rst2_rgb", {16'd0, px}, 32'd0);
    check("rst2_ready", {31'd0, s_ready}, 32'd1);
    @(negedge PixelClk);
    nRST = 1'b1;

    // early SOF as 4th pixel of a running frame
    start_producer(16'h0C00, 6, 0, 3);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b1);
      expect_px("early_px", 16'h0C00 + 16'(k), 1'b0);
    end
    step(1'b1, 1'b0, 1'b1);
    expect_px("early_fill", 16'h0000, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    expect_px("early_idle", 16'h0000, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int k = 3; k < 6; k++) begin
      step(1'b1, 1'b0, 1'b1);
      expect_px("early_next", 16'h0C00 + 16'(k), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
